// File: rtl/clawgame_pkg.sv
// Shared claw-game definitions: prize-chute FSM states, default timing constants
// and the counter width helper.
package clawgame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEB_ON,
    PULSE,
    WAIT_REL,
    LOCKOUT
  } state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
  localparam int unsigned LOCKOUT_CYCLES_DEF  = 64;

  // Wide enough to hold the larger of the two terminal counts without wrapping.
  function automatic int unsigned cnt_width(int unsigned deb, int unsigned lock);
    int unsigned biggest;
    biggest = (deb > lock) ? deb : lock;
    return $clog2(biggest + 1);
  endfunction

endpackage

// File: rtl/clawgame_sync2.sv
// Two-flop synchroniser with synchronous active-high reset for asynchronous
// single-bit inputs.
module clawgame_sync2 (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b0;
      dout <= 1'b0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/prize_sensor_conditioner.sv
// Turns the raw chute break-beam into one increment_score pulse per prize drop.
// Define PRIZE_COUNT_EN to build the saturating prize_count tally.
module prize_sensor_conditioner
  import clawgame_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEF,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sensor_raw,
  output logic             increment_score,
  output logic             busy,
  output logic [CNT_W-1:0] prize_count
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, LOCKOUT_CYCLES);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCKOUT_CYCLES - 1);

  logic          sensor_sync;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  clawgame_sync2 u_sync (
    .clock (clock),
    .reset (reset),
    .din   (sensor_raw),
    .dout  (sensor_sync)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (enable && sensor_sync) begin
          state_d = DEB_ON;
          cnt_d   = CW'(1);
        end
      end
      DEB_ON: begin
        if (!enable || !sensor_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PULSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PULSE: begin
        state_d = WAIT_REL;
        cnt_d   = '0;
      end
      WAIT_REL: begin
        // Any high sample means the prize is still in the beam: restart release count.
        if (sensor_sync) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = LOCKOUT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOCKOUT: begin
        if (cnt_q == LOCK_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign increment_score = (state_q == PULSE);
  assign busy            = (state_q != IDLE);

`ifdef PRIZE_COUNT_EN
  logic [CNT_W-1:0] tally_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      tally_q <= '0;
    end else if ((state_q == PULSE) && (tally_q != {CNT_W{1'b1}})) begin
      tally_q <= tally_q + 1'b1;
    end
  end

  assign prize_count = tally_q;
`else
  assign prize_count = '0;
`endif

endmodule

// File: tb/tb_prize_sensor_conditioner.sv
// Scoreboard bench for prize_sensor_conditioner: expected pulse cycles are queued
// as stimulus is driven and matched against increment_score every cycle.
module tb_prize_sensor_conditioner;

  localparam int unsigned DEB = 4;
  localparam int unsigned LOCK = 8;
  localparam int unsigned CW = 8;

  logic          clock;
  logic          reset;
  logic          enable;
  logic          sensor_raw;
  logic          increment_score;
  logic          busy;
  logic [CW-1:0] prize_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_prizes = 0;
  int exp_q[$];

  prize_sensor_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .LOCKOUT_CYCLES  (LOCK),
    .CNT_W           (CW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .sensor_raw      (sensor_raw),
    .increment_score (increment_score),
    .busy            (busy),
    .prize_count     (prize_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [CW-1:0] exp_count();
`ifdef PRIZE_COUNT_EN
    return exp_prizes[CW-1:0];
`else
    return '0;
`endif
  endfunction

  task automatic expect_pulse(input int at);
    exp_q.push_back(at);
    if (exp_prizes < 255) exp_prizes++;
  endtask

  // One clock; sample #1 after the edge and match any pulse against the scoreboard.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (exp_q.size() > 0 && exp_q[0] < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_pulse: no pulse by cycle %0d, required at cycle %0d", cyc - 1, exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (increment_score !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: increment_score=%b at cycle %0d, required 0", increment_score, cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (e != cyc) begin
          errors++;
          $display("FAIL pulse_timing: pulse at cycle %0d, required at cycle %0d", cyc, e);
        end
      end
    end
  endtask

  task automatic tick_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_prizes = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b0;
    sensor_raw = 1'b0;
    repeat (3) tick();
    checks++;
    if (increment_score !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulse: got %b, required 0", increment_score);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b, required 0", busy);
    end
    checks++;
    if (prize_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d, required 0", prize_count);
    end
    reset = 1'b0;
    enable = 1'b1;
    tick();
  endtask

  task automatic test_clean_drop();
    int n, m;
    n = cyc;
    sensor_raw = 1'b1;
    expect_pulse(n + 6);
    tick_until(n + 3);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL clean_debounce_busy: got %b, required 1", busy);
    end
    // Dropping enable after the pulse must not disturb release or lockout.
    tick_until(n + 8);
    enable = 1'b0;
    tick_until(n + 20);
    sensor_raw = 1'b0;
    m = cyc;
    tick_until(m + 13);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL clean_busy_hold: got %b at cycle %0d, required 1", busy, cyc);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL clean_busy_clear: got %b at cycle %0d, required 0", busy, cyc);
    end
    enable = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL clean_pending: %0d pulses outstanding, required 0", exp_q.size());
    end
    checks++;
    if (prize_count !== exp_count()) begin
      errors++;
      $display("FAIL clean_count: got %0d, required %0d", prize_count, exp_count());
    end
  endtask

  task automatic test_glitch();
    int n;
    n = cyc;
    sensor_raw = 1'b1;
    tick_until(n + 3);
    sensor_raw = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_deb_on: busy=%b, required 1", busy);
    end
    tick_until(n + 5);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_last_sample: busy=%b, required 1", busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_idle: busy=%b at cycle %0d, required 0", busy, cyc);
    end
    tick_until(n + 12);
    checks++;
    if (prize_count !== exp_count()) begin
      errors++;
      $display("FAIL glitch_count: got %0d, required %0d", prize_count, exp_count());
    end
  endtask

  task automatic test_release_bounce();
    int n, m;
    n = cyc;
    sensor_raw = 1'b1;
    expect_pulse(n + 6);
    tick_until(n + 10);
    for (int i = 0; i < 6; i++) begin
      sensor_raw = (i % 2 == 1);
      tick();
    end
    sensor_raw = 1'b0;
    m = cyc;
    tick_until(m + 13);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL bounce_busy_hold: got %b at cycle %0d, required 1", busy, cyc);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bounce_busy_clear: got %b at cycle %0d, required 0", busy, cyc);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bounce_pending: %0d pulses outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_stuck_rearm();
    int n, m, p, q;
    do_reset();
    enable = 1'b1;
    n = cyc;
    sensor_raw = 1'b1;
    expect_pulse(n + 6);
    tick_until(n + 100);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL stuck_wait_rel: busy=%b, required 1", busy);
    end
    sensor_raw = 1'b0;
    m = cyc;
    tick_until(m + 14);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stuck_release: busy=%b, required 0", busy);
    end
    p = cyc;
    sensor_raw = 1'b1;
    expect_pulse(p + 6);
    tick_until(p + 10);
    sensor_raw = 1'b0;
    q = cyc;
    tick_until(q + 14);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rearm_idle: busy=%b, required 0", busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rearm_pending: %0d pulses outstanding, required 0", exp_q.size());
    end
    checks++;
    if (prize_count !== exp_count()) begin
      errors++;
      $display("FAIL rearm_count: got %0d, required %0d", prize_count, exp_count());
    end
  endtask

  task automatic test_lockout_exit();
    int n, m, r;
    n = cyc;
    sensor_raw = 1'b1;
    expect_pulse(n + 6);
    tick_until(n + 8);
    sensor_raw = 1'b0;
    m = cyc;
    tick_until(m + 8);
    // Beam returns while locked out; a fresh full debounce must follow.
    sensor_raw = 1'b1;
    expect_pulse(m + 18);
    tick_until(m + 14);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL lockout_exit_idle: busy=%b at cycle %0d, required 0", busy, cyc);
    end
    tick_until(m + 22);
    sensor_raw = 1'b0;
    r = cyc;
    tick_until(r + 14);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL lockout_pending: %0d pulses outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_abort_reset();
    int n;
    n = cyc;
    sensor_raw = 1'b1;
    tick_until(n + 3);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_deb_on: busy=%b, required 1", busy);
    end
    enable = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b, required 0", busy);
    end
    tick_until(n + 12);
    sensor_raw = 1'b0;
    enable = 1'b1;
    tick_until(n + 16);
    n = cyc;
    sensor_raw = 1'b1;
    expect_pulse(n + 6);
    tick_until(n + 6);
    reset = 1'b1;
    sensor_raw = 1'b0;
    tick();
    checks++;
    if (increment_score !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pulse: increment_score=%b, required 0", increment_score);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_busy: busy=%b, required 0", busy);
    end
    checks++;
    if (prize_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_count: got %0d, required 0", prize_count);
    end
    tick();
    reset = 1'b0;
    exp_prizes = 0;
    repeat (6) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_pending: %0d pulses outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_clean_drop();
    test_glitch();
    test_release_bounce();
    test_stuck_rearm();
    test_lockout_exit();
    test_abort_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
